// File: rtl/seg_scan_3digit.sv
// Three-digit multiplexed 7-segment scanner with per-digit blank guard and frame snapshot.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN suppresses leading "0" patterns on digits 2 and 1.
module seg_scan_3digit #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  output logic [7:0] seg_out,
  output logic [2:0] dig_en,
  output logic       frame_done
);

  // state | meaning
  // BLANK | all digits off for BLANK_DIV cycles ahead of the current digit (idle while en=0)
  // SHOW  | current digit driven from the snapshot for SCAN_DIV cycles
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_LAST = (BLANK_DIV == 0) ? 16'd0 : 16'(BLANK_DIV - 1);
  localparam bit          NO_BLANK   = (BLANK_DIV == 0);
  localparam logic [7:0]  PAT_ZERO   = 8'b1111_1100;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  snap0_q, snap1_q, snap2_q;
  logic        snap_load;
  logic [7:0]  pat_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= 16'd0;
      snap0_q <= 8'h00;
      snap1_q <= 8'h00;
      snap2_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (snap_load) begin
        snap0_q <= seg0;
        snap1_q <= seg1;
        snap2_q <= seg2;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    snap_load = 1'b0;
    if (!en) begin
      state_d = ST_BLANK;
      idx_d   = 2'd0;
      cnt_d   = 16'd0;
    end else if (state_q == ST_BLANK) begin
      if (NO_BLANK || (cnt_q == BLANK_LAST)) begin
        state_d = ST_SHOW;
        cnt_d   = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      if (cnt_q == SCAN_LAST) begin
        idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        cnt_d   = 16'd0;
        state_d = NO_BLANK ? ST_SHOW : ST_BLANK;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    // New frame begins exactly when we move into SHOW for digit 0 from anywhere else.
    snap_load = (state_d == ST_SHOW) && (idx_d == 2'd0) &&
                !((state_q == ST_SHOW) && (idx_q == 2'd0));
  end

  always_comb begin
    pat_sel = 8'h00;
    case (idx_q)
      2'd0:    pat_sel = snap0_q;
      2'd1:    pat_sel = snap1_q;
      2'd2:    pat_sel = snap2_q;
      default: pat_sel = 8'h00;
    endcase
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if ((idx_q == 2'd2) && (snap2_q == PAT_ZERO))
      pat_sel = 8'h00;
    if ((idx_q == 2'd1) && (snap1_q == PAT_ZERO) && (snap2_q == PAT_ZERO))
      pat_sel = 8'h00;
`endif
  end

  always_comb begin
    dig_en     = 3'b000;
    seg_out    = 8'h00;
    frame_done = 1'b0;
    if (state_q == ST_SHOW) begin
      case (idx_q)
        2'd0:    dig_en = 3'b001;
        2'd1:    dig_en = 3'b010;
        2'd2:    dig_en = 3'b100;
        default: dig_en = 3'b000;
      endcase
      seg_out    = pat_sel;
      frame_done = (idx_q == 2'd2) && (cnt_q == SCAN_LAST);
    end
  end

`ifndef SEG_LEADING_ZERO_BLANK_EN
  logic unused_pat_zero;
  assign unused_pat_zero = ^PAT_ZERO;
`endif

endmodule

// File: tb/tb_seg_scan_3digit.sv
// Scoreboard bench: two scanners (BLANK_DIV=2 and BLANK_DIV=0) against a frame-position model.
module tb_seg_scan_3digit;

  localparam int S   = 4;
  localparam int B_A = 2;
  localparam int B_B = 0;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [7:0] seg0, seg1, seg2;
  logic [7:0] a_seg, b_seg;
  logic [2:0] a_dig, b_dig;
  logic       a_fd, b_fd;

  always #5 clk = ~clk;

  seg_scan_3digit #(.SCAN_DIV(S), .BLANK_DIV(B_A)) dut_a (
    .clk(clk), .rst(rst), .en(en), .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .seg_out(a_seg), .dig_en(a_dig), .frame_done(a_fd));

  seg_scan_3digit #(.SCAN_DIV(S), .BLANK_DIV(B_B)) dut_b (
    .clk(clk), .rst(rst), .en(en), .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .seg_out(b_seg), .dig_en(b_dig), .frame_done(b_fd));

  typedef struct packed {
    logic [2:0] dig;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: number of enabled edges since idle, and the frame snapshot.
  int         na, nb;
  logic [7:0] sa0, sa1, sa2, sb0, sb1, sb2;

  function automatic exp_t model(input int n, input int b, input int s,
                                 input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    exp_t e;
    int off, per, p, d, w;
    e   = '0;
    off = (b == 0) ? 1 : 0;
    if (n >= off) begin
      per = 3 * (b + s);
      p   = (n - off) % per;
      d   = p / (b + s);
      w   = p % (b + s);
      if (w >= b) begin
        e.dig = 3'(1 << d);
        e.seg = (d == 0) ? p0 : (d == 1) ? p1 : p2;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (d == 2 && p2 == 8'hFC) e.seg = 8'h00;
        if (d == 1 && p1 == 8'hFC && p2 == 8'hFC) e.seg = 8'h00;
`endif
        e.fd = (p == per - 1);
      end
    end
    return e;
  endfunction

  function automatic bit frame_start(input int n, input int b, input int s);
    int off;
    off = (b == 0) ? 1 : 0;
    return (n >= off) && (((n - off) % (3 * (b + s))) == b);
  endfunction

  task automatic model_reset();
    na = 0; nb = 0;
    sa0 = 8'h00; sa1 = 8'h00; sa2 = 8'h00;
    sb0 = 8'h00; sb1 = 8'h00; sb2 = 8'h00;
  endtask

  task automatic model_edge();
    na = en ? na + 1 : 0;
    nb = en ? nb + 1 : 0;
    if (frame_start(na, B_A, S)) begin sa0 = seg0; sa1 = seg1; sa2 = seg2; end
    if (frame_start(nb, B_B, S)) begin sb0 = seg0; sb1 = seg1; sb2 = seg2; end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({a_dig, a_seg, a_fd, b_dig, b_seg, b_fd} !== '0) begin
      failures++;
      $display("FAIL %s: a dig=%b seg=%h fd=%b b dig=%b seg=%h fd=%b, required all zero",
               tag, a_dig, a_seg, a_fd, b_dig, b_seg, b_fd);
    end
  endtask

  // One clock: advance model over the edge, optionally assert async reset, queue expectations.
  task automatic tick(input bit do_rst);
    @(posedge clk);
    #1;
    if (!rst) model_reset();
    else      model_edge();
    if (do_rst) begin
      rst = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
    end
    qa.push_back(model(na, B_A, S, sa0, sa1, sa2));
    qb.push_back(model(nb, B_B, S, sb0, sb1, sb2));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      checks++;
      if ({a_dig, a_seg, a_fd} !== {e.dig, e.seg, e.fd}) begin
        failures++;
        $display("FAIL dut_a t=%0t: dig=%b seg=%h fd=%b, required dig=%b seg=%h fd=%b",
                 $time, a_dig, a_seg, a_fd, e.dig, e.seg, e.fd);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      checks++;
      if ({b_dig, b_seg, b_fd} !== {e.dig, e.seg, e.fd}) begin
        failures++;
        $display("FAIL dut_b t=%0t: dig=%b seg=%h fd=%b, required dig=%b seg=%h fd=%b",
                 $time, b_dig, b_seg, b_fd, e.dig, e.seg, e.fd);
      end
    end
    checks++;
    if ($countones(a_dig) > 1 || $countones(b_dig) > 1) begin
      failures++;
      $display("FAIL onehot t=%0t: a dig=%b b dig=%b, required at most one bit", $time, a_dig, b_dig);
    end
  end

  initial begin
    int         en_hold, rst_hold;
    bit         do_rst;
    logic [7:0] v;
    rst = 1'b0; en = 1'b0; seg0 = 8'h00; seg1 = 8'h00; seg2 = 8'h00;
    model_reset();
    #1;
    check_reset_outputs("reset_state");
    repeat (2) tick(1'b0);
    rst = 1'b1; en = 1'b1; seg0 = 8'h60; seg1 = 8'hDA; seg2 = 8'hF2;

    // Directed frame: seg1 changes mid-frame, then en drop, then reset mid-frame.
    for (int c = 0; c < 40; c++) begin
      tick(1'b0);
      if (c == 3) seg1 = 8'hE0;
    end
    for (int c = 0; c < 30; c++) begin
      tick(1'b0);
      if (c == 8)  en = 1'b0;
      if (c == 11) en = 1'b1;
    end
    for (int c = 0; c < 14; c++) tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    rst = 1'b1;
    for (int c = 0; c < 40; c++) tick(1'b0);

    // Leading-zero patterns.
    seg0 = 8'hFC; seg1 = 8'hFC; seg2 = 8'hFC;
    for (int c = 0; c < 40; c++) tick(1'b0);
    seg1 = 8'h60;
    for (int c = 0; c < 40; c++) tick(1'b0);

    // Randomized traffic with en drops and async resets.
    en_hold = 0; rst_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      do_rst = rst && (rst_hold == 0) && ($urandom_range(399) == 0);
      tick(do_rst);
      if (do_rst) rst_hold = $urandom_range(2, 1);
      else if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
      end
      if (en_hold > 0) begin
        en_hold--;
        if (en_hold == 0) en = 1'b1;
      end else if ($urandom_range(59) == 0) begin
        en = 1'b0;
        en_hold = $urandom_range(5, 1);
      end
      if ($urandom_range(3) == 0) begin
        v = ($urandom_range(1) == 0) ? 8'hFC : 8'($urandom);
        case ($urandom_range(2))
          0:       seg0 = v;
          1:       seg1 = v;
          default: seg2 = v;
        endcase
      end
    end

    @(negedge clk);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain: pending a=%0d b=%0d, required 0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
